// File: rtl/mux_8to1_using_mux_2to1_if.sv
// Bus bundle for the registered 8-to-1 mux: eight data lanes, three select
// bits and the registered result. The master drives data/select and samples y.
interface mux_8to1_using_mux_2to1_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] f;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] h;
   logic             s0;
   logic             s1;
   logic             s2;
   logic [WIDTH-1:0] y;

   modport master (
      output a, b, c, d, e, f, g, h,
      output s0, s1, s2,
      input  y
   );

   modport slave (
      input  a, b, c, d, e, f, g, h,
      input  s0, s1, s2,
      output y
   );
endinterface

// File: rtl/mux_8to1_using_mux_2to1.sv
// Registered 8-to-1 multiplexer built as a three-level tree of seven 2-to-1
// cells. Select code {s2,s1,s0} picks a..h; y is registered.
// Build option MUX8_PIPELINE_EN: registers after level 1 and level 2 with s1/s2
// delayed to travel alongside their data (latency 3). Without it the tree is
// purely combinational into the y register (latency 1). Reset is synchronous,
// active-high, and clears every stage including the delayed selects.

module mux_2to1 #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);
   assign out = sel ? in1 : in0;
endmodule

module mux_8to1_using_mux_2to1 #(
   parameter int WIDTH = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   mux_8to1_using_mux_2to1_if.slave     bus
);

   // level 1 outputs, always fed straight from the inputs with s0
   logic [WIDTH-1:0] m0, m1, m2, m3;
   // level 2 outputs and level 3 result
   logic [WIDTH-1:0] n0, n1, r;
   logic [WIDTH-1:0] y_q;

   mux_2to1 #(.WIDTH(WIDTH)) u_m0 (.in0(bus.a), .in1(bus.b), .sel(bus.s0), .out(m0));
   mux_2to1 #(.WIDTH(WIDTH)) u_m1 (.in0(bus.c), .in1(bus.d), .sel(bus.s0), .out(m1));
   mux_2to1 #(.WIDTH(WIDTH)) u_m2 (.in0(bus.e), .in1(bus.f), .sel(bus.s0), .out(m2));
   mux_2to1 #(.WIDTH(WIDTH)) u_m3 (.in0(bus.g), .in1(bus.h), .sel(bus.s0), .out(m3));

`ifdef MUX8_PIPELINE_EN
   logic [WIDTH-1:0] m0_q, m1_q, m2_q, m3_q;
   logic [WIDTH-1:0] n0_q, n1_q;
   logic             s1_d1;
   logic             s2_d1;
   logic             s2_d2;

   mux_2to1 #(.WIDTH(WIDTH)) u_n0 (.in0(m0_q), .in1(m1_q), .sel(s1_d1), .out(n0));
   mux_2to1 #(.WIDTH(WIDTH)) u_n1 (.in0(m2_q), .in1(m3_q), .sel(s1_d1), .out(n1));
   mux_2to1 #(.WIDTH(WIDTH)) u_r  (.in0(n0_q), .in1(n1_q), .sel(s2_d2), .out(r));

   // pipeline stages and matching select delays; reset flushes in-flight data
   always_ff @(posedge clk) begin
      if (rst) begin
         m0_q  <= '0;
         m1_q  <= '0;
         m2_q  <= '0;
         m3_q  <= '0;
         s1_d1 <= 1'b0;
         s2_d1 <= 1'b0;
         n0_q  <= '0;
         n1_q  <= '0;
         s2_d2 <= 1'b0;
         y_q   <= '0;
      end else begin
         m0_q  <= m0;
         m1_q  <= m1;
         m2_q  <= m2;
         m3_q  <= m3;
         s1_d1 <= bus.s1;
         s2_d1 <= bus.s2;
         n0_q  <= n0;
         n1_q  <= n1;
         s2_d2 <= s2_d1;
         y_q   <= r;
      end
   end
`else
   mux_2to1 #(.WIDTH(WIDTH)) u_n0 (.in0(m0), .in1(m1), .sel(bus.s1), .out(n0));
   mux_2to1 #(.WIDTH(WIDTH)) u_n1 (.in0(m2), .in1(m3), .sel(bus.s1), .out(n1));
   mux_2to1 #(.WIDTH(WIDTH)) u_r  (.in0(n0), .in1(n1), .sel(bus.s2), .out(r));

   // single output register behind the combinational tree
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q <= '0;
      end else begin
         y_q <= r;
      end
   end
`endif

   assign bus.y = y_q;

endmodule

// File: tb/tb_mux_8to1_using_mux_2to1.sv
// Directed bench for mux_8to1_using_mux_2to1 at WIDTH = 4. Each step drives
// one vector with its hand-derived selected value; a small delay line of
// expected values accounts for the build's latency.
module tb_mux_8to1_using_mux_2to1;

`ifdef MUX8_PIPELINE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   mux_8to1_using_mux_2to1_if #(.WIDTH(4)) bus ();

   mux_8to1_using_mux_2to1 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [3:0] pipe_q[$];

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: y=%h expected %h", tag, got, exp);
      end
   endtask

   // dv packs {h,g,f,e,d,c,b,a}, one nibble each
   task automatic step(input string tag, input logic r, input logic [31:0] dv,
                       input logic [2:0] sel, input logic [3:0] exp);
      logic [3:0] want;
      rst   = r;
      bus.a = dv[3:0];
      bus.b = dv[7:4];
      bus.c = dv[11:8];
      bus.d = dv[15:12];
      bus.e = dv[19:16];
      bus.f = dv[23:20];
      bus.g = dv[27:24];
      bus.h = dv[31:28];
      {bus.s2, bus.s1, bus.s0} = sel;
      @(posedge clk);
      #1;
      if (r) begin
         pipe_q.delete();
         for (int k = 0; k < LAT - 1; k++) pipe_q.push_back(4'h0);
         want = 4'h0;
      end else begin
         pipe_q.push_back(exp);
         want = pipe_q.pop_front();
      end
      chk(tag, bus.y, want);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with all inputs at 1, then release and watch the 1 emerge
      step("rst0", 1'b1, 32'h1111_1111, 3'd0, 4'h0);
      step("rst1", 1'b1, 32'h1111_1111, 3'd0, 4'h0);
      for (int i = 0; i < 4; i++)
         step($sformatf("rel%0d", i), 1'b0, 32'h1111_1111, 3'd0, 4'h1);

      // one-hot walk with sel = 000: only the a step selects the 1
      for (int i = 0; i < 8; i++) begin
         logic [31:0] dv;
         dv = 32'h0000_0001 << (4 * i);
         step($sformatf("walk%0d", i), 1'b0, dv, 3'd0, (i == 0) ? 4'h1 : 4'h0);
      end

      // select sweep with only h = 1
      for (int i = 1; i < 8; i++)
         step($sformatf("sweep%0d", i), 1'b0, 32'h1000_0000, 3'(i),
              (i == 7) ? 4'h1 : 4'h0);

      // full mapping a..h = 0..7
      for (int i = 0; i < 8; i++)
         step($sformatf("map%0d", i), 1'b0, 32'h7654_3210, 3'(i), 4'(i));

      // distinct non-ordinal values
      step("mix_c", 1'b0, 32'h9E3C_5A7F, 3'd2, 4'hA);
      step("mix_f", 1'b0, 32'h9E3C_5A7F, 3'd5, 4'h3);
      step("mix_h", 1'b0, 32'h9E3C_5A7F, 3'd7, 4'h9);
      step("mix_b", 1'b0, 32'h9E3C_5A7F, 3'd1, 4'h7);

      // mid-stream reset during a sweep
      for (int i = 0; i < 8; i++)
         step($sformatf("mrst%0d", i), (i == 4) ? 1'b1 : 1'b0,
              32'hFEDC_BA98, 3'(i), 4'(8 + i));

      // select and data change together: a/h swapped while sel goes 000 -> 111
      step("simul0", 1'b0, 32'hC000_0003, 3'd0, 4'h3);
      step("simul1", 1'b0, 32'h3000_000C, 3'd7, 4'h3);
      step("simul2", 1'b0, 32'h6000_000A, 3'd7, 4'h6);
      step("simul3", 1'b0, 32'h6000_000A, 3'd0, 4'hA);

      // drain the pipeline
      for (int i = 0; i < 3; i++)
         step($sformatf("drain%0d", i), 1'b0, 32'h0000_0000, 3'd0, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
